// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The package holds the FSM state encoding and the NOP/HALT words.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Wide enough for a hold window of up to 15 cycles.
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, datapath and control unit.
// The master side is the fetch unit; the slave side is its environment.
interface instruction_fetch_unit_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 8
);
    import fetch_pkg::*;

    // Memory handshake: im_read stays high with im_addr stable until an im_valid
    // cycle; the edge that sees im_read and im_valid both high consumes im_data.
    logic                  im_read;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic [SIZE-1:0]       im_data;
    logic                  im_valid;

    logic                  branch_en;
    logic [ADDR_WIDTH-1:0] branch_target;

    logic [SIZE-1:0]       instruction;
    logic                  instr_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;
    fetch_state_e          dbg_state;

    modport master (
        output im_read, im_addr, instruction, instr_valid, pc, halted, dbg_state,
        input  im_data, im_valid, branch_en, branch_target
    );

    modport slave (
        input  im_read, im_addr, instruction, instr_valid, pc, halted, dbg_state,
        output im_data, im_valid, branch_en, branch_target
    );

endinterface

// File: rtl/fetch_pc_register.sv
// Program counter with wrap-around increment, plus the branch latch that
// remembers the last redirect seen during the current instruction window.
module fetch_pc_register #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_en_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic                  br_q, br_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            tgt_q <= '0;
            br_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            tgt_q <= tgt_d;
            br_q  <= br_d;
        end
    end

    // A redirect arriving on the final issue cycle goes straight into the PC.
    always_comb begin
        pc_d  = pc_q;
        tgt_d = tgt_q;
        br_d  = br_q;
        if (advance_i) begin
            if (branch_en_i) begin
                pc_d = branch_target_i;
            end else if (br_q) begin
                pc_d = tgt_q;
            end else begin
                pc_d = pc_q + 1'b1;
            end
            br_d = 1'b0;
        end else if (branch_en_i) begin
            br_d  = 1'b1;
            tgt_d = branch_target_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches instruction words, holds each for CYCLES_PER_INSTR cycles for the
// control unit, applies datapath branch redirects and stops on HALT_WORD.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              SIZE             = 32,
    parameter int              ADDR_WIDTH       = 8,
    parameter int              CYCLES_PER_INSTR = 4,
    parameter logic [SIZE-1:0] HALT_WORD        = SIZE'(DEFAULT_HALT_WORD)
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      start,
    instruction_fetch_unit_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CYCLES_PER_INSTR - 1);

    fetch_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]       instr_q, instr_d;
    logic                  last_issue;
    logic                  issue_branch;
    logic [ADDR_WIDTH-1:0] pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= SIZE'(NOP_WORD);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        last_issue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.im_valid) begin
                    // A HALT word is never shown to the control unit.
                    if (bus.im_data == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end else begin
                        instr_d = bus.im_data;
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_COUNT) begin
                    last_issue = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign issue_branch = (state_q == ST_ISSUE) && bus.branch_en;

    fetch_pc_register #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_pc (
        .clk            (clk),
        .reset          (reset),
        .branch_en_i    (issue_branch),
        .branch_target_i(bus.branch_target),
        .advance_i      (last_issue),
        .pc_o           (pc)
    );

    assign bus.im_read     = (state_q == ST_FETCH);
    assign bus.im_addr     = pc;
    assign bus.pc          = pc;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = (state_q == ST_ISSUE);
    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle behavioural model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam int          SIZE = 32;
    localparam int          AW   = 8;
    localparam int          CPI  = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_ISSUE = 2;
    localparam int M_HALT  = 3;

    typedef struct {
        int          mode;
        logic [7:0]  pc;
        logic [31:0] instr;
        int          left;
        bit          br;
        logic [7:0]  tgt;
    } model_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          br_en = 1'b0;
    logic [AW-1:0] br_tgt = '0;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_data = '0;
    logic          force_valid = 1'b0;
    logic [31:0]   force_data = '0;
    int            wait_cfg = 0;
    int            wait_cnt = 0;
    logic [31:0]   mem [256];
    int            checks = 0;
    int            errors = 0;
    bit            chk_en = 1'b0;
    model_t        m = '{M_IDLE, 8'h00, 32'h0, 0, 1'b0, 8'h00};

    instruction_fetch_unit_if #(.SIZE(SIZE), .ADDR_WIDTH(AW)) bus ();

    assign bus.im_valid      = mem_valid | force_valid;
    assign bus.im_data       = force_valid ? force_data : mem_data;
    assign bus.branch_en     = br_en;
    assign bus.branch_target = br_tgt;

    instruction_fetch_unit #(
        .SIZE            (SIZE),
        .ADDR_WIDTH      (AW),
        .CYCLES_PER_INSTR(CPI),
        .HALT_WORD       (HALT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory with a configurable number of wait cycles per read.
    always @(posedge clk) begin
        #1;
        if (bus.im_read && wait_cnt >= wait_cfg) begin
            mem_valid = 1'b1;
            mem_data  = mem[bus.im_addr];
            wait_cnt  = 0;
        end else if (bus.im_read) begin
            mem_valid = 1'b0;
            wait_cnt  = wait_cnt + 1;
        end else begin
            mem_valid = 1'b0;
            wait_cnt  = 0;
        end
    end

    function automatic model_t model_next(model_t cur, logic rst, logic st, logic v,
                                          logic [31:0] d, logic be, logic [7:0] bt);
        model_t n = cur;
        if (rst) begin
            n = '{M_IDLE, 8'h00, 32'h0, 0, 1'b0, 8'h00};
            return n;
        end
        case (cur.mode)
            M_IDLE: if (st) n.mode = M_FETCH;
            M_FETCH: begin
                if (v) begin
                    if (d == HALT) begin
                        n.mode = M_HALT;
                    end else begin
                        n.mode  = M_ISSUE;
                        n.instr = d;
                        n.left  = CPI;
                    end
                end
            end
            M_ISSUE: begin
                if (be) begin
                    n.br  = 1'b1;
                    n.tgt = bt;
                end
                n.left = cur.left - 1;
                if (n.left == 0) begin
                    n.pc   = n.br ? n.tgt : 8'((int'(cur.pc) + 1) % 256);
                    n.br   = 1'b0;
                    n.mode = M_FETCH;
                end
            end
            default: n = cur;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, start, bus.im_valid, bus.im_data, bus.branch_en, bus.branch_target);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_instr_valid", 32'(bus.instr_valid), 32'(m.mode == M_ISSUE));
            check("m_im_read",     32'(bus.im_read),     32'(m.mode == M_FETCH));
            check("m_halted",      32'(bus.halted),      32'(m.mode == M_HALT));
            check("m_pc",          32'(bus.pc),          32'(m.pc));
            check("m_im_addr",     32'(bus.im_addr),     32'(m.pc));
            check("m_instruction", bus.instruction,      m.instr);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
        for (int i = 0; i < 4; i++) mem[i] = 32'(i);

        // Reset state
        reset = 1'b1;
        step(2);
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_instruction", bus.instruction, 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_im_read", 32'(bus.im_read), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_state_idle", 32'(bus.dbg_state == ST_IDLE), 32'h1);

        // Sequential fetch, zero-wait memory
        step(1);
        pulse_start();
        @(negedge clk);
        check("seq_first_fetch_read", 32'(bus.im_read), 32'h1);
        check("seq_first_fetch_addr", 32'(bus.im_addr), 32'h0);
        check("seq_first_fetch_iv", 32'(bus.instr_valid), 32'h0);
        step(1);
        @(negedge clk);
        check("seq_word0_iv", 32'(bus.instr_valid), 32'h1);
        step(5);
        @(negedge clk);
        check("seq_word1", bus.instruction, 32'h1);
        check("seq_pc1", 32'(bus.pc), 32'h1);
        step(10);
        @(negedge clk);
        check("seq_word3", bus.instruction, 32'h3);
        check("seq_pc3", 32'(bus.pc), 32'h3);

        // Memory wait states
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
        wait_cfg = 3;
        pulse_start();
        step(2);
        @(negedge clk);
        check("wait_read_held", 32'(bus.im_read), 32'h1);
        check("wait_addr0", 32'(bus.im_addr), 32'h0);
        check("wait_iv_low", 32'(bus.instr_valid), 32'h0);
        check("wait_nop_kept", bus.instruction, 32'h0);
        step(8);
        @(negedge clk);
        check("wait_addr1", 32'(bus.im_addr), 32'h1);
        check("wait_old_word_kept", bus.instruction, 32'hC000_0000);
        check("wait2_iv_low", 32'(bus.instr_valid), 32'h0);

        // Branch redirects
        do_reset();
        wait_cfg = 0;
        pulse_start();
        step(7);
        br_en = 1'b1; br_tgt = 8'h10;
        step(1);
        br_en = 1'b0;
        step(2);
        @(negedge clk);
        check("br_target_10", 32'(bus.im_addr), 32'h10);
        step(1);
        br_en = 1'b1; br_tgt = 8'h40;
        step(1);
        br_en = 1'b0;
        step(1);
        br_en = 1'b1; br_tgt = 8'h20;
        step(1);
        br_en = 1'b0;
        step(1);
        @(negedge clk);
        check("br_last_wins_20", 32'(bus.im_addr), 32'h20);
        step(4);
        br_en = 1'b1; br_tgt = 8'h33;
        step(1);
        br_tgt = 8'h77;
        @(negedge clk);
        check("br_final_cycle_33", 32'(bus.im_addr), 32'h33);
        step(1);
        br_en = 1'b0;
        step(4);
        @(negedge clk);
        check("br_fetch_ignored_34", 32'(bus.im_addr), 32'h34);

        // Halt at address 2
        do_reset();
        mem[2] = HALT;
        pulse_start();
        step(11);
        @(negedge clk);
        check("halt_halted", 32'(bus.halted), 32'h1);
        check("halt_im_read", 32'(bus.im_read), 32'h0);
        check("halt_iv", 32'(bus.instr_valid), 32'h0);
        check("halt_instruction_kept", bus.instruction, 32'hC000_0001);
        check("halt_pc", 32'(bus.pc), 32'h2);
        step(1);
        pulse_start();
        step(3);
        @(negedge clk);
        check("halt_start_ignored", 32'(bus.halted), 32'h1);
        check("halt_state", 32'(bus.dbg_state == ST_HALTED), 32'h1);

        // PC wrap from 0xFF
        do_reset();
        mem[2] = 32'hC000_0002;
        pulse_start();
        step(1);
        br_en = 1'b1; br_tgt = 8'hFF;
        step(1);
        br_en = 1'b0;
        step(3);
        @(negedge clk);
        check("wrap_addr_ff", 32'(bus.im_addr), 32'hFF);
        step(5);
        @(negedge clk);
        check("wrap_addr_00", 32'(bus.im_addr), 32'h0);

        // Reset on the third issue cycle of address 1
        do_reset();
        pulse_start();
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        force_valid = 1'b1; force_data = 32'h5555_5555;
        @(negedge clk);
        check("rmid_pc", 32'(bus.pc), 32'h0);
        check("rmid_instruction", bus.instruction, 32'h0);
        check("rmid_iv", 32'(bus.instr_valid), 32'h0);
        check("rmid_state_idle", 32'(bus.dbg_state == ST_IDLE), 32'h1);
        step(1);
        force_valid = 1'b0;
        step(2);
        @(negedge clk);
        check("rmid_late_valid_ignored", bus.instruction, 32'h0);
        check("rmid_still_idle", 32'(bus.im_read), 32'h0);
        step(1);
        pulse_start();
        @(negedge clk);
        check("rmid_restart_read", 32'(bus.im_read), 32'h1);
        check("rmid_restart_addr", 32'(bus.im_addr), 32'h0);
        step(1);
        @(negedge clk);
        check("rmid_restart_word", bus.instruction, 32'hC000_0000);

        step(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the multi-cycle datapath: reads instruction words from instruction memory and presents each one to `control_unit` on its `instruction` input. Each word is held stable for exactly CYCLES_PER_INSTR clock cycles, matching the control unit's per-instruction execution window. The block owns the program counter, applies branch redirects from the datapath, and stops on a HALT word.

## Interface
- SIZE, 32: instruction width in bits.
- ADDR_WIDTH, 8: program-counter and instruction-memory address width in bits.
- CYCLES_PER_INSTR, 4: cycles each instruction is held; legal range 1..15.
- HALT_WORD, 32'hFFFF_FFFF: fetched word that stops the unit.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins fetching; honoured only in IDLE.
- im_read  out  1  instruction-memory read request.
- im_addr  out  ADDR_WIDTH  read address; always equals pc.
- im_data  in  SIZE  read data; valid when im_valid is high.
- im_valid  in  1  read-data strobe; may arrive any number of cycles after the request.
- branch_en  in  1  redirect request; honoured only in ISSUE.
- branch_target  in  ADDR_WIDTH  redirect address.
- instruction  out  SIZE  word driven to the control unit.
- instr_valid  out  1  high while instruction is being executed.
- pc  out  ADDR_WIDTH  current program counter.
- halted  out  1  high once HALT_WORD has been fetched.

## Operation
- State machine states are IDLE, FETCH, ISSUE and HALTED.
- **Reset values:** state=IDLE, pc=0, instruction=32'h0000_0000 (NOP), instr_valid=0, im_read=0, halted=0, issue counter=0, branch latch clear.
- **IDLE:**
  - start=1 → FETCH.
  - Otherwise stay in IDLE.
- **FETCH:**
  - im_read=1 and im_addr=pc.
  - instruction holds its previous value; instr_valid=0.
  - On an edge with im_valid=1 and im_data≠HALT_WORD: instruction←im_data, counter←0, go to ISSUE.
  - On an edge with im_valid=1 and im_data==HALT_WORD: go to HALTED. instruction is not updated and pc does not change.
- **ISSUE:**
  - instr_valid=1 and im_read=0. im_valid is ignored.
  - The counter increments every cycle.
  - On the cycle where the counter equals CYCLES_PER_INSTR−1: update pc and go to FETCH.
  - pc update: if the branch latch is set, pc←latched target and the latch clears; otherwise pc←pc+1.
- **Branch handling:**
  - A branch_en sampled on any ISSUE cycle, including the last, sets the latch and captures branch_target.
  - If several branch_en pulses occur in one instruction, the last one wins.
  - branch_en outside ISSUE is ignored.
- **HALTED:**
  - halted=1, instr_valid=0, im_read=0.
  - start is ignored. Only reset leaves this state.
- **PC arithmetic:**
  - pc+1 is computed modulo 2^ADDR_WIDTH, so the last address wraps to 0.
  - branch_target is used verbatim.
- start asserted outside IDLE has no effect.

## Timing
- Reset asserted on any edge, including mid-FETCH or mid-ISSUE, forces all reset values at that edge. An im_valid still in flight afterwards is ignored because the unit is in IDLE.
- Start-up latency: start sampled at edge k gives FETCH during cycle k+1. With im_valid in that same cycle, ISSUE begins at edge k+2.
- With zero-wait memory, one instruction takes 1 + CYCLES_PER_INSTR cycles. Each wait cycle adds one.
- instr_valid is high for exactly CYCLES_PER_INSTR consecutive cycles per instruction. instruction is constant for that whole window.
- pc changes only at the final-ISSUE edge or at reset. Consequently im_addr is stable throughout FETCH.
- halted rises at the edge that samples HALT_WORD and stays high until reset.

## Structure
- Package `fetch_pkg` holds:
  - the state encoding (IDLE, FETCH, ISSUE, HALTED);
  - constants NOP_WORD=32'h0000_0000 and HALT_WORD default 32'hFFFF_FFFF;
  - the counter width localparam (4 bits).
- One sub-module, `fetch_pc_register`, contains:
  - the PC register, including reset, increment with wrap, and load from the branch latch;
  - the branch latch.
- The FSM and the issue counter stay in the top module.

## Test plan
- **Sequential fetch:** memory words 0x0,0x1,0x2,0x3 at addresses 0..3, zero wait, pulse start → each word shown with instr_valid=1 for exactly 4 cycles, one idle FETCH cycle between words, pc goes 0→1→2→3.
- **Memory wait states:** im_valid delayed 3 cycles per read → im_read held high with im_addr stable, instr_valid=0 during the wait, instruction keeps its old value.
- **Branch:** branch_en=1 with target 0x10 on the 2nd ISSUE cycle of address 1 → next im_addr=0x10. A second pulse with target 0x20 in the same window → im_addr=0x20.
- **Halt:** HALT_WORD at address 2 → after address 1 retires, halted=1 and im_read=0; instruction stays at address 1's word; a later start is ignored.
- **PC wrap:** pc=0xFF with no branch → next fetch address is 0x00.
- **Reset mid-ISSUE:** reset on 3rd ISSUE cycle → next cycle pc=0, instruction=0, instr_valid=0, state IDLE. A late im_valid is ignored. Fetching restarts only after start.
